// File: rtl/ctrl_pkg.sv
// Purpose: shared opcodes, control encodings and the packed decode struct for pipe_ctrl_unit.
// Latency: none (declarations only).
// Backpressure: not applicable.
package ctrl_pkg;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLT,
    ALU_SLTU, ALU_SLL, ALU_SRL, ALU_SRA, ALU_PASSB
  } alu_ctrl_e;

  typedef enum logic [1:0] {RES_ALU, RES_MEM, RES_PC4, RES_MDU} result_src_e;

  typedef enum logic [2:0] {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_src_e;

  typedef enum logic [1:0] {DIV_IDLE, DIV_BUSY, DIV_DONE} div_state_e;

  // Everything the later stages need from one decoded instruction.
  typedef struct packed {
    logic        reg_write;
    logic        mem_write;
    logic        branch;
    logic        jump;
    logic        jalr;
    logic [1:0]  alu_src_a;
    logic        alu_src_b;
    alu_ctrl_e   alu_ctrl;
    result_src_e result_src;
    logic        mdu;
    logic        is_div;
    logic [2:0]  funct3;
  } ctrl_t;

endpackage

// File: rtl/instr_decoder.sv
// Purpose: combinational D-stage decode of RV32I(+M) into a ctrl_t bundle plus illegal flag.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; illegal encodings decode to an all-zero (NOP) bundle.
module instr_decoder
  import ctrl_pkg::*;
(
  input  logic [6:0] op_i,
  input  logic [2:0] funct3_i,
  input  logic [6:0] funct7_i,
  output ctrl_t      ctrl_o,
  output imm_src_e   imm_src_o,
  output logic       illegal_o
);

  alu_ctrl_e alu_f3;
  logic      shift_ok;

  // ALU op implied by funct3 for OP/OP-IMM; funct7[5] picks SRA over SRL.
  always_comb begin
    alu_f3 = ALU_ADD;
    case (funct3_i)
      3'b001:  alu_f3 = ALU_SLL;
      3'b010:  alu_f3 = ALU_SLT;
      3'b011:  alu_f3 = ALU_SLTU;
      3'b100:  alu_f3 = ALU_XOR;
      3'b101:  alu_f3 = funct7_i[5] ? ALU_SRA : ALU_SRL;
      3'b110:  alu_f3 = ALU_OR;
      3'b111:  alu_f3 = ALU_AND;
      default: alu_f3 = ALU_ADD;
    endcase
    shift_ok = 1'b1;
    if (funct3_i == 3'b001) shift_ok = (funct7_i == F7_BASE);
    if (funct3_i == 3'b101) shift_ok = (funct7_i == F7_BASE) || (funct7_i == F7_ALT);
  end

  // Opcode decode; anything unsupported is flagged and squashed to a NOP.
  always_comb begin
    ctrl_o        = '0;
    ctrl_o.funct3 = funct3_i;
    imm_src_o     = IMM_I;
    illegal_o     = 1'b0;
    case (op_i)
      OP_LUI: begin
        ctrl_o.reg_write = 1'b1;
        ctrl_o.alu_src_a = 2'b10;
        ctrl_o.alu_src_b = 1'b1;
        imm_src_o        = IMM_U;
      end
      OP_AUIPC: begin
        ctrl_o.reg_write = 1'b1;
        ctrl_o.alu_src_a = 2'b01;
        ctrl_o.alu_src_b = 1'b1;
        imm_src_o        = IMM_U;
      end
      OP_JAL: begin
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.jump       = 1'b1;
        ctrl_o.alu_src_a  = 2'b01;
        ctrl_o.alu_src_b  = 1'b1;
        ctrl_o.result_src = RES_PC4;
        imm_src_o         = IMM_J;
      end
      OP_JALR: begin
        illegal_o         = (funct3_i != 3'b000);
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.jump       = 1'b1;
        ctrl_o.jalr       = 1'b1;
        ctrl_o.alu_src_b  = 1'b1;
        ctrl_o.result_src = RES_PC4;
      end
      OP_BRANCH: begin
        illegal_o       = (funct3_i[2:1] == 2'b01);
        ctrl_o.branch   = 1'b1;
        ctrl_o.alu_ctrl = ALU_SUB;
        imm_src_o       = IMM_B;
      end
      OP_LOAD: begin
        illegal_o         = (funct3_i == 3'b011) || (funct3_i[2:1] == 2'b11);
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.alu_src_b  = 1'b1;
        ctrl_o.result_src = RES_MEM;
      end
      OP_STORE: begin
        illegal_o        = funct3_i[2] || (funct3_i[1:0] == 2'b11);
        ctrl_o.mem_write = 1'b1;
        ctrl_o.alu_src_b = 1'b1;
        imm_src_o        = IMM_S;
      end
      OP_IMM: begin
        illegal_o        = !shift_ok;
        ctrl_o.reg_write = 1'b1;
        ctrl_o.alu_src_b = 1'b1;
        ctrl_o.alu_ctrl  = alu_f3;
      end
      OP_OP: begin
        if (funct7_i == F7_BASE ||
            (funct7_i == F7_ALT && (funct3_i == 3'b000 || funct3_i == 3'b101))) begin
          ctrl_o.reg_write = 1'b1;
          ctrl_o.alu_ctrl  = (funct7_i[5] && funct3_i == 3'b000) ? ALU_SUB : alu_f3;
        end else if (funct7_i == F7_MULDIV) begin
`ifdef CTRL_MDU_EN
          ctrl_o.reg_write  = 1'b1;
          ctrl_o.mdu        = 1'b1;
          ctrl_o.is_div     = funct3_i[2];
          ctrl_o.result_src = RES_MDU;
`else
          illegal_o = 1'b1;
`endif
        end else begin
          illegal_o = 1'b1;
        end
      end
      OP_SYSTEM: ;
      default: illegal_o = 1'b1;
    endcase
    if (illegal_o) begin
      ctrl_o = '0;
    end
  end

endmodule

// File: rtl/pipe_ctrl_unit.sv
// Purpose: pipelined D->E->M->W control path with branch resolution and divide stall FSM (CTRL_MDU_EN adds M-ext).
// Latency: D decode to W outputs in 3 clock edges; branch/jump redirect visible in E one edge after decode.
// Backpressure: stall_o holds D/E for DIV_LATENCY cycles per divide; E/M loads a bubble, M/W keeps draining.
module pipe_ctrl_unit
  import ctrl_pkg::*;
#(
  parameter int ALU_CTRL_W  = 4,
  parameter int DIV_LATENCY = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [6:0]            op_i,
  input  logic [2:0]            funct3_i,
  input  logic [6:0]            funct7_i,
  input  logic                  flush_e_i,
  input  logic                  zero_e_i,
  input  logic                  lt_e_i,
  input  logic                  ltu_e_i,
  output logic [2:0]            imm_src_d_o,
  output logic                  illegal_d_o,
  output logic                  pc_src_e_o,
  output logic                  pc_tgt_alu_e_o,
  output logic [1:0]            alu_src_a_e_o,
  output logic                  alu_src_b_e_o,
  output logic [ALU_CTRL_W-1:0] alu_control_e_o,
  output logic [1:0]            result_src_e_o,
  output logic                  mdu_start_e_o,
  output logic [2:0]            mdu_op_e_o,
  output logic                  stall_o,
  output logic                  mem_write_m_o,
  output logic [2:0]            mem_funct3_m_o,
  output logic                  reg_write_m_o,
  output logic                  reg_write_w_o,
  output logic [1:0]            result_src_w_o
);

  ctrl_t       ctrl_d, ctrl_e;
  imm_src_e    imm_src_d;
  logic        valid_e, valid_m;
  logic        reg_write_m, mem_write_m, reg_write_w;
  logic [2:0]  mem_funct3_m;
  result_src_e result_src_m, result_src_w;
  logic        stall;
  logic        branch_cond;

  instr_decoder u_dec (
    .op_i      (op_i),
    .funct3_i  (funct3_i),
    .funct7_i  (funct7_i),
    .ctrl_o    (ctrl_d),
    .imm_src_o (imm_src_d),
    .illegal_o (illegal_d_o)
  );

  assign imm_src_d_o = imm_src_d;

  // D/E register: flush beats stall, stall holds the divide in E.
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_e_i) begin
      ctrl_e  <= '0;
      valid_e <= 1'b0;
    end else if (!stall) begin
      ctrl_e  <= ctrl_d;
      valid_e <= 1'b1;
    end
  end

  // E/M register: a stalled E stage hands M a bubble.
  always_ff @(posedge clk_i) begin
    if (rst_i || stall) begin
      valid_m      <= 1'b0;
      reg_write_m  <= 1'b0;
      mem_write_m  <= 1'b0;
      mem_funct3_m <= 3'b000;
      result_src_m <= RES_ALU;
    end else begin
      valid_m      <= valid_e;
      reg_write_m  <= valid_e & ctrl_e.reg_write;
      mem_write_m  <= valid_e & ctrl_e.mem_write;
      mem_funct3_m <= ctrl_e.funct3;
      result_src_m <= ctrl_e.result_src;
    end
  end

  // M/W register: always advances so older work drains during a stall.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      reg_write_w  <= 1'b0;
      result_src_w <= RES_ALU;
    end else begin
      reg_write_w  <= valid_m & reg_write_m;
      result_src_w <= result_src_m;
    end
  end

  // Branch condition from funct3 and the datapath comparator flags.
  always_comb begin
    case (ctrl_e.funct3)
      3'b000:  branch_cond = zero_e_i;
      3'b001:  branch_cond = !zero_e_i;
      3'b100:  branch_cond = lt_e_i;
      3'b101:  branch_cond = !lt_e_i;
      3'b110:  branch_cond = ltu_e_i;
      3'b111:  branch_cond = !ltu_e_i;
      default: branch_cond = 1'b0;
    endcase
  end

  assign pc_src_e_o      = valid_e & (ctrl_e.jump | (ctrl_e.branch & branch_cond));
  assign pc_tgt_alu_e_o  = valid_e & ctrl_e.jalr;
  assign alu_src_a_e_o   = ctrl_e.alu_src_a;
  assign alu_src_b_e_o   = ctrl_e.alu_src_b;
  assign alu_control_e_o = ALU_CTRL_W'(ctrl_e.alu_ctrl);
  assign result_src_e_o  = ctrl_e.result_src;
  assign mem_write_m_o   = mem_write_m;
  assign mem_funct3_m_o  = mem_funct3_m;
  assign reg_write_m_o   = reg_write_m;
  assign reg_write_w_o   = reg_write_w;
  assign result_src_w_o  = result_src_w;
  assign stall_o         = stall;

`ifdef CTRL_MDU_EN
  localparam int DIV_CNT_W = $clog2(DIV_LATENCY + 1);

  div_state_e           state, state_n;
  logic [DIV_CNT_W-1:0] cnt, cnt_n;
  logic                 div_e, start;

  assign div_e = valid_e & ctrl_e.is_div;

  // Divide FSM state and remaining-cycle counter.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= DIV_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  // IDLE cycle plus DIV_LATENCY-1 BUSY cycles stall; DONE lets E move on
  // without re-triggering the same divide.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    start   = 1'b0;
    stall   = 1'b0;
    case (state)
      DIV_IDLE: begin
        if (div_e) begin
          start   = 1'b1;
          stall   = 1'b1;
          cnt_n   = DIV_CNT_W'(DIV_LATENCY - 1);
          state_n = (DIV_LATENCY == 1) ? DIV_DONE : DIV_BUSY;
        end
      end
      DIV_BUSY: begin
        stall = 1'b1;
        cnt_n = cnt - DIV_CNT_W'(1);
        if (cnt <= DIV_CNT_W'(1)) state_n = DIV_DONE;
      end
      DIV_DONE: state_n = DIV_IDLE;
      default:  state_n = DIV_IDLE;
    endcase
    if (flush_e_i) begin
      state_n = DIV_IDLE;
    end
  end

  assign mdu_start_e_o = start;
  assign mdu_op_e_o    = (valid_e & ctrl_e.mdu) ? ctrl_e.funct3 : 3'b000;
`else
  logic unused_mdu;
  assign unused_mdu    = ^{ctrl_e.mdu, ctrl_e.is_div, 32'(DIV_LATENCY)};
  assign stall         = 1'b0;
  assign mdu_start_e_o = 1'b0;
  assign mdu_op_e_o    = 3'b000;
`endif

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Purpose: directed self-checking bench for pipe_ctrl_unit (DIV_LATENCY=4).
// Latency: checks sampled 1 time unit after each rising edge.
// Backpressure: divide stall measured with a bounded loop.
module tb_pipe_ctrl_unit;

  localparam logic [6:0] LUI = 7'b0110111, JAL = 7'b1101111, JALR = 7'b1100111;
  localparam logic [6:0] BR  = 7'b1100011, LD  = 7'b0000011, ST   = 7'b0100011;
  localparam logic [6:0] OPR = 7'b0110011, SYS = 7'b1110011;

  logic       clk = 1'b0;
  logic       rst, flush, zero, lt, ltu;
  logic [6:0] op, f7;
  logic [2:0] f3;
  logic [2:0] imm_src, mdu_op, mem_f3;
  logic       illegal, pc_src, pc_tgt, alu_b, mdu_start, stall;
  logic       mem_wr_m, reg_wr_m, reg_wr_w;
  logic [1:0] alu_a, res_e, res_w;
  logic [3:0] alu_ctl;
  int         checks = 0;
  int         failures = 0;

  always #5 clk = ~clk;

  pipe_ctrl_unit #(.ALU_CTRL_W(4), .DIV_LATENCY(4)) dut (
    .clk_i(clk), .rst_i(rst), .op_i(op), .funct3_i(f3), .funct7_i(f7),
    .flush_e_i(flush), .zero_e_i(zero), .lt_e_i(lt), .ltu_e_i(ltu),
    .imm_src_d_o(imm_src), .illegal_d_o(illegal), .pc_src_e_o(pc_src),
    .pc_tgt_alu_e_o(pc_tgt), .alu_src_a_e_o(alu_a), .alu_src_b_e_o(alu_b),
    .alu_control_e_o(alu_ctl), .result_src_e_o(res_e), .mdu_start_e_o(mdu_start),
    .mdu_op_e_o(mdu_op), .stall_o(stall), .mem_write_m_o(mem_wr_m),
    .mem_funct3_m_o(mem_f3), .reg_write_m_o(reg_wr_m), .reg_write_w_o(reg_wr_w),
    .result_src_w_o(res_w)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [6:0] o, input logic [2:0] f, input logic [6:0] s);
    op = o; f3 = f; f7 = s;
    #1;
  endtask

  task automatic drain();
    drive(SYS, 3'b000, 7'h00);
    repeat (3) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; zero = 1'b0; lt = 1'b0; ltu = 1'b0;
    drive(7'h7F, 3'b000, 7'h00);
    repeat (2) tick();
    checks++; if (pc_src !== 1'b0) begin failures++; $display("FAIL rst_pc_src: got %0h expected 0", pc_src); end
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL rst_stall: got %0h expected 0", stall); end
    checks++; if ({reg_wr_m, mem_wr_m, reg_wr_w, res_w} !== 5'b0) begin failures++; $display("FAIL rst_mw_regs: got %0h expected 0", {reg_wr_m, mem_wr_m, reg_wr_w, res_w}); end
    checks++; if (illegal !== 1'b1) begin failures++; $display("FAIL rst_illegal_comb: got %0h expected 1", illegal); end
    rst = 1'b0;
    drain();
  endtask

  task automatic test_decode();
    drive(LUI, 3'b000, 7'h00);
    checks++; if ({illegal, imm_src} !== {1'b0, 3'd3}) begin failures++; $display("FAIL dec_lui: got %0h expected 3", {illegal, imm_src}); end
    tick();
    drive(JAL, 3'b000, 7'h00);
    checks++; if ({alu_a, alu_b} !== 3'b101) begin failures++; $display("FAIL e_lui_srcs: got %0h expected 5", {alu_a, alu_b}); end
    checks++; if (imm_src !== 3'd4) begin failures++; $display("FAIL dec_jal_imm: got %0h expected 4", imm_src); end
    drive(ST, 3'b010, 7'h00);
    checks++; if (imm_src !== 3'd1) begin failures++; $display("FAIL dec_sw_imm: got %0h expected 1", imm_src); end
    drive(OPR, 3'b000, 7'h20);
    tick();
    drive(SYS, 3'b000, 7'h00);
    checks++; if ({alu_ctl, alu_b} !== {4'd1, 1'b0}) begin failures++; $display("FAIL e_sub_alu: got %0h expected 2", {alu_ctl, alu_b}); end
    drain();
  endtask

  task automatic test_branch();
    drive(BR, 3'b000, 7'h00); tick();                  // BEQ in E
    zero = 1'b1; drive(BR, 3'b000, 7'h00);
    checks++; if (pc_src !== 1'b1) begin failures++; $display("FAIL beq_taken: got %0h expected 1", pc_src); end
    tick(); zero = 1'b0; drive(BR, 3'b001, 7'h00);
    checks++; if (pc_src !== 1'b0) begin failures++; $display("FAIL beq_not_taken: got %0h expected 0", pc_src); end
    tick(); drive(BR, 3'b100, 7'h00);                  // BNE, zero=0
    checks++; if (pc_src !== 1'b1) begin failures++; $display("FAIL bne_taken: got %0h expected 1", pc_src); end
    tick(); lt = 1'b1; drive(BR, 3'b101, 7'h00);       // BLT, lt=1
    checks++; if (pc_src !== 1'b1) begin failures++; $display("FAIL blt_taken: got %0h expected 1", pc_src); end
    tick(); drive(BR, 3'b110, 7'h00);                  // BGE, lt=1
    checks++; if (pc_src !== 1'b0) begin failures++; $display("FAIL bge_not_taken: got %0h expected 0", pc_src); end
    tick(); lt = 1'b0; ltu = 1'b1; drive(BR, 3'b111, 7'h00);  // BLTU
    checks++; if (pc_src !== 1'b1) begin failures++; $display("FAIL bltu_taken: got %0h expected 1", pc_src); end
    tick(); drive(JALR, 3'b000, 7'h00);                // BGEU, ltu=1
    checks++; if (pc_src !== 1'b0) begin failures++; $display("FAIL bgeu_not_taken: got %0h expected 0", pc_src); end
    tick(); ltu = 1'b0; drive(JAL, 3'b000, 7'h00);     // JALR
    checks++; if ({pc_src, pc_tgt, res_e} !== 4'b1110) begin failures++; $display("FAIL jalr: got %0h expected e", {pc_src, pc_tgt, res_e}); end
    tick(); drive(SYS, 3'b000, 7'h00);                 // JAL
    checks++; if ({pc_src, pc_tgt} !== 2'b10) begin failures++; $display("FAIL jal: got %0h expected 2", {pc_src, pc_tgt}); end
    tick();
    checks++; if (pc_src !== 1'b0) begin failures++; $display("FAIL nop_no_redirect: got %0h expected 0", pc_src); end
    drain();
  endtask

  task automatic test_store_flush();
    drive(ST, 3'b010, 7'h00); flush = 1'b1;
    tick(); flush = 1'b0; drive(SYS, 3'b000, 7'h00);
    tick();
    checks++; if (mem_wr_m !== 1'b0) begin failures++; $display("FAIL flushed_sw_m: got %0h expected 0", mem_wr_m); end
    drive(ST, 3'b010, 7'h00); tick(); drive(SYS, 3'b000, 7'h00); tick();
    checks++; if ({mem_wr_m, mem_f3, reg_wr_m} !== 5'b10100) begin failures++; $display("FAIL sw_m: got %0h expected 14", {mem_wr_m, mem_f3, reg_wr_m}); end
    drain();
  endtask

  task automatic test_illegal();
    drive(7'h7F, 3'b000, 7'h00);
    checks++; if (illegal !== 1'b1) begin failures++; $display("FAIL op7f_illegal: got %0h expected 1", illegal); end
    drive(BR, 3'b010, 7'h00);
    checks++; if (illegal !== 1'b1) begin failures++; $display("FAIL br010_illegal: got %0h expected 1", illegal); end
    drive(LD, 3'b111, 7'h00);
    checks++; if (illegal !== 1'b1) begin failures++; $display("FAIL ld111_illegal: got %0h expected 1", illegal); end
    tick(); drive(SYS, 3'b000, 7'h00); tick();
    checks++; if ({reg_wr_m, mem_wr_m} !== 2'b00) begin failures++; $display("FAIL illegal_m_writes: got %0h expected 0", {reg_wr_m, mem_wr_m}); end
    tick();
    checks++; if (reg_wr_w !== 1'b0) begin failures++; $display("FAIL illegal_w_write: got %0h expected 0", reg_wr_w); end
    drive(LD, 3'b010, 7'h00);
    checks++; if (illegal !== 1'b0) begin failures++; $display("FAIL lw_legal: got %0h expected 0", illegal); end
    tick(); drive(SYS, 3'b000, 7'h00); tick(); tick();
    checks++; if ({reg_wr_w, res_w} !== 3'b101) begin failures++; $display("FAIL lw_w: got %0h expected 5", {reg_wr_w, res_w}); end
    drain();
  endtask

  task automatic test_mdu();
    int n;
    int starts;
    int guard;
`ifdef CTRL_MDU_EN
    drive(OPR, 3'b100, 7'h01);
    checks++; if (illegal !== 1'b0) begin failures++; $display("FAIL div_legal: got %0h expected 0", illegal); end
    tick(); drive(SYS, 3'b000, 7'h00);
    checks++; if ({mdu_start, stall, mdu_op} !== 5'b11100) begin failures++; $display("FAIL div_start: got %0h expected 1c", {mdu_start, stall, mdu_op}); end
    n = 0; starts = 0; guard = 0;
    while (stall === 1'b1 && guard < 20) begin
      n++; starts += int'(mdu_start); guard++;
      tick();
    end
    checks++; if (n !== 4) begin failures++; $display("FAIL div_stall_len: got %0d expected 4", n); end
    checks++; if (starts !== 1) begin failures++; $display("FAIL div_start_pulses: got %0d expected 1", starts); end
    checks++; if (mdu_start !== 1'b0) begin failures++; $display("FAIL div_done_no_restart: got %0h expected 0", mdu_start); end
    tick();
    checks++; if (reg_wr_m !== 1'b1) begin failures++; $display("FAIL div_m: got %0h expected 1", reg_wr_m); end
    tick();
    checks++; if ({reg_wr_w, res_w} !== 3'b111) begin failures++; $display("FAIL div_w: got %0h expected 7", {reg_wr_w, res_w}); end
    drive(OPR, 3'b000, 7'h01); tick(); drive(SYS, 3'b000, 7'h00);
    checks++; if ({stall, mdu_start} !== 2'b00) begin failures++; $display("FAIL mul_no_stall: got %0h expected 0", {stall, mdu_start}); end
`else
    n = 0; starts = 0; guard = 0;
    drive(OPR, 3'b000, 7'h01);
    checks++; if (illegal !== 1'b1) begin failures++; $display("FAIL mul_illegal: got %0h expected 1", illegal); end
    drive(OPR, 3'b100, 7'h01);
    checks++; if (illegal !== 1'b1) begin failures++; $display("FAIL div_illegal: got %0h expected 1", illegal); end
    tick(); drive(SYS, 3'b000, 7'h00);
    checks++; if ({stall, mdu_start, mdu_op} !== 5'b0) begin failures++; $display("FAIL div_no_stall: got %0h expected 0", {stall, mdu_start, mdu_op}); end
`endif
    drain();
  endtask

  task automatic test_reset_mid_busy();
    int n;
    int guard;
    drive(OPR, 3'b000, 7'h00); tick();            // ADD in E
`ifdef CTRL_MDU_EN
    drive(OPR, 3'b101, 7'h01); tick();            // DIVU in E, ADD in M
    drive(SYS, 3'b000, 7'h00); tick();            // BUSY, ADD in W
    checks++; if (stall !== 1'b1) begin failures++; $display("FAIL busy_before_rst: got %0h expected 1", stall); end
`else
    drive(SYS, 3'b000, 7'h00); tick();            // ADD in M
`endif
    rst = 1'b1; tick(); rst = 1'b0;
    checks++; if ({stall, mdu_start, pc_src, reg_wr_m, mem_wr_m, reg_wr_w, res_w} !== 8'b0) begin failures++; $display("FAIL rst_mid_flight: got %0h expected 0", {stall, mdu_start, pc_src, reg_wr_m, mem_wr_m, reg_wr_w, res_w}); end
`ifdef CTRL_MDU_EN
    drive(OPR, 3'b100, 7'h01); tick(); drive(SYS, 3'b000, 7'h00);
    n = 0; guard = 0;
    while (stall === 1'b1 && guard < 20) begin
      n++; guard++;
      tick();
    end
    checks++; if (n !== 4) begin failures++; $display("FAIL div_after_rst_len: got %0d expected 4", n); end
`else
    n = 0; guard = 0;
`endif
    drain();
  endtask

  initial begin
    test_reset();
    test_decode();
    test_branch();
    test_store_flush();
    test_illegal();
    test_mdu();
    test_reset_mid_busy();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
